data_mem_ctrl: RTL and testbench

Data-memory controller sitting directly downstream of the RV32I core's data port (funct3, write enable, address, write data), replacing a plain RAM. It owns a word-wide single-port synchronous RAM and implements all RV32I load/store widths. Word stores complete in one cycle. Sub-word stores use a two-cycle read-modify-write, and loads take two cycles with sign/zero extension. The core is held through `oStall` while an access is in progress.

---
 rtl/data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Data-memory controller for an RV32I core's data port. It owns a word-wide,
// single-port synchronous RAM (one access per cycle, one-cycle read latency)
// and implements every RV32I load/store width:
//   - sw      : written in the request cycle, no stall.
//   - sb / sh : read-modify-write over two cycles (read, then merged write).
//   - loads   : read, then lane select with sign/zero extension next cycle.
// Misaligned requests (and reserved funct3 codes) are dropped with a
// one-cycle oMisalign pulse.
//
// Parameters
//   ADDR_W        word-address bits; memory is 2^ADDR_W x 32 bits.
//
// Ports
//   iClk          system clock, rising edge.
//   iRst          asynchronous, active-low reset; also blocks RAM writes.
//   iFunct3       access width: 000 b, 001 h, 010 w, 100 bu, 101 hu.
//   iData_WrEn    store request (wins over iData_RdEn when both are high).
//   iData_RdEn    load request.
//   iData_Addr    byte address; upper bits beyond the RAM size are ignored.
//   iData_WrData  store data; byte/half taken from the low bits.
//   oData_RdData  extended load result, zero whenever oRdValid is low.
//   oRdValid      load result valid this cycle.
//   oStall        core must hold PC and all request inputs.
//   oMisalign     one-cycle pulse: misaligned access dropped.
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [2:0]        iFunct3,
    input  logic              iData_WrEn,
    input  logic              iData_RdEn,
    input  logic [31:0]       iData_Addr,
    input  logic [31:0]       iData_WrData,
    output logic [31:0]       oData_RdData,
    output logic              oRdValid,
    output logic              oStall,
    output logic              oMisalign
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MERGE,
        LOAD_RSP
    } state_t;

    state_t state;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] in_idx;
    logic [1:0]        in_off;
    logic              req_any;
    logic              misaligned;
    logic              accept;
    logic              store_word;
    logic              store_sub;
    logic              load_req;

    assign in_idx  = iData_Addr[ADDR_W+1:2];
    assign in_off  = iData_Addr[1:0];
    assign req_any = iData_WrEn | iData_RdEn;

    // Upper address bits are deliberately dropped so addresses wrap modulo
    // the memory size.
    logic unused_addr;
    assign unused_addr = ^iData_Addr[31:ADDR_W+2];

    always_comb begin
        unique case (iFunct3)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = in_off[0];
            F3_W:        misaligned = |in_off;
            default:     misaligned = 1'b1;   // 011/110/111 are not RV32I widths
        endcase
    end

    // Reset gates acceptance so no request can start or write while iRst is low.
    assign accept     = iRst && (state == IDLE) && req_any && !misaligned;
    assign store_word = accept && iData_WrEn && (iFunct3 == F3_W);
    assign store_sub  = accept && iData_WrEn && (iFunct3 != F3_W);
    // A store takes priority: RdEn alongside WrEn is ignored.
    assign load_req   = accept && !iData_WrEn;

    // -------------------------------------------------------------------------
    // Captured request for the second cycle of a stalled access. The core holds
    // its inputs anyway; capturing keeps the second cycle independent of them.
    // -------------------------------------------------------------------------
    logic [2:0]        req_f3;
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_idx;
    logic [31:0]       req_wdata;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            req_f3    <= '0;
            req_off   <= '0;
            req_idx   <= '0;
            req_wdata <= '0;
        end else if (store_sub || load_req) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            req_f3    <= iFunct3;
            req_off   <= in_off;
            req_idx   <= in_idx;
            req_wdata <= iData_WrData;
        end
    end

    // -------------------------------------------------------------------------
    // Single-port RAM with registered read data
    // -------------------------------------------------------------------------
    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_wdata;
    logic [31:0]       merged;

    // NOTE: the array has no reset branch; clearing it would turn the RAM into
    // thousands of resettable flops. Its read register follows suit.
    always_ff @(posedge iClk) begin
        if (ram_we) begin
            mem[ram_idx] <= ram_wdata;
        end
        if (ram_re) begin
            ram_q <= mem[ram_idx];
        end
    end

    // Byte/half merge of the freshly read word with the held store data.
    always_comb begin
        merged = ram_q;
        if (req_f3[1:0] == 2'b00) begin
            unique case (req_off)
                2'd0: merged[7:0]   = req_wdata[7:0];
                2'd1: merged[15:8]  = req_wdata[7:0];
                2'd2: merged[23:16] = req_wdata[7:0];
                2'd3: merged[31:24] = req_wdata[7:0];
            endcase
        end else if (req_off[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0]  = req_wdata[15:0];
        end
    end

    // Load lane select and extension.
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign lane = ram_q >> {req_off, 3'b000};

    always_comb begin
        unique case (req_f3)
            F3_B:    load_ext = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_ext = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   load_ext = {24'd0, lane[7:0]};
            F3_HU:   load_ext = {16'd0, lane[15:0]};
            default: load_ext = ram_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state, RAM control and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave a signal unassigned and infer a latch.
        state_next   = state;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_idx      = in_idx;
        ram_wdata    = iData_WrData;
        oData_RdData = '0;
        oRdValid     = 1'b0;
        oStall       = 1'b0;
        oMisalign    = 1'b0;

        unique case (state)
            IDLE: begin
                oMisalign = iRst && req_any && misaligned;
                oStall    = store_sub || load_req;
                if (store_word) begin
                    ram_we = 1'b1;
                end else if (store_sub) begin
                    ram_re     = 1'b1;
                    state_next = MERGE;
                end else if (load_req) begin
                    ram_re     = 1'b1;
                    state_next = LOAD_RSP;
                end
            end

            MERGE: begin
                ram_idx    = req_idx;
                ram_wdata  = merged;
                // Reset here aborts the merge and leaves the word untouched.
                ram_we     = iRst;
                state_next = IDLE;
            end

            LOAD_RSP: begin
                oRdValid     = 1'b1;
                oData_RdData = load_ext;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Directed bench for data_mem_ctrl. Loads push their hand-computed result onto
// a scoreboard queue when issued; an independent monitor pops and compares
// whenever the DUT asserts oRdValid. Stall, misalign and reset behaviour are
// checked inline against hand-given constants.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic        iClk;
    logic        iRst;
    logic [2:0]  iFunct3;
    logic        iData_WrEn;
    logic        iData_RdEn;
    logic [31:0] iData_Addr;
    logic [31:0] iData_WrData;
    logic [31:0] oData_RdData;
    logic        oRdValid;
    logic        oStall;
    logic        oMisalign;

    data_mem_ctrl #(.ADDR_W(8)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iFunct3      (iFunct3),
        .iData_WrEn   (iData_WrEn),
        .iData_RdEn   (iData_RdEn),
        .iData_Addr   (iData_Addr),
        .iData_WrData (iData_WrData),
        .oData_RdData (oData_RdData),
        .oRdValid     (oRdValid),
        .oStall       (oStall),
        .oMisalign    (oMisalign)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid load result must match the oldest expectation.
    always @(negedge iClk) begin : monitor
        exp_t e;
        if (oRdValid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdvalid: got data 0x%08h expected no response", oData_RdData);
            end else begin
                e = sb_q.pop_front();
                check(e.name, oData_RdData, e.data);
            end
        end
    end

    // One request, driven #1 after a rising edge. Stalled requests are held
    // for their second cycle. Inputs are dropped afterwards unless the next
    // op follows immediately.
    task automatic op(input string name, input logic [2:0] f3, input logic we, input logic re,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_stall, input logic exp_mis, input logic [31:0] exp_rd);
        iFunct3      = f3;
        iData_WrEn   = we;
        iData_RdEn   = re;
        iData_Addr   = addr;
        iData_WrData = wdata;
        if (re && !we && !exp_mis) sb_q.push_back('{name, exp_rd});
        @(negedge iClk);
        check({name, "_stall"}, {31'd0, oStall}, {31'd0, exp_stall});
        check({name, "_misalign"}, {31'd0, oMisalign}, {31'd0, exp_mis});
        check({name, "_rddata_idle"}, oData_RdData, 32'd0);
        @(posedge iClk);
        #1;
        if (exp_stall) begin
            @(negedge iClk);
            check({name, "_stall_2nd"}, {31'd0, oStall}, 32'd0);
            @(posedge iClk);
            #1;
        end
        iData_WrEn = 1'b0;
        iData_RdEn = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        iRst         = 1'b0;
        iFunct3      = '0;
        iData_WrEn   = 1'b0;
        iData_RdEn   = 1'b0;
        iData_Addr   = '0;
        iData_WrData = '0;

        // Reset state
        @(negedge iClk);
        check("rst_rddata",   oData_RdData, 32'd0);
        check("rst_rdvalid",  {31'd0, oRdValid}, 32'd0);
        check("rst_stall",    {31'd0, oStall}, 32'd0);
        check("rst_misalign", {31'd0, oMisalign}, 32'd0);
        @(negedge iClk);
        iRst = 1'b1;
        @(posedge iClk);
        #1;

        // Store word then back-to-back load
        op("sw10", W, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        op("lw10", W, 0, 1, 32'h10, 32'h0,        1, 0, 32'hDEADBEEF);

        // Byte merge
        op("sw20", W, 1, 0, 32'h20, 32'h11223344, 0, 0, 0);
        op("sb22", B, 1, 0, 32'h22, 32'h000000AA, 1, 0, 0);
        op("lw20", W, 0, 1, 32'h20, 32'h0,        1, 0, 32'h11AA3344);

        // Half and byte extension
        op("sw30",  W,  1, 0, 32'h30, 32'h8001F0FF, 0, 0, 0);
        op("lh32",  H,  0, 1, 32'h32, 32'h0,        1, 0, 32'hFFFF8001);
        op("lhu32", HU, 0, 1, 32'h32, 32'h0,        1, 0, 32'h00008001);
        op("lb30",  B,  0, 1, 32'h30, 32'h0,        1, 0, 32'hFFFFFFFF);
        op("lbu31", BU, 0, 1, 32'h31, 32'h0,        1, 0, 32'h000000F0);
        op("lh30",  H,  0, 1, 32'h30, 32'h0,        1, 0, 32'hFFFFF0FF);

        // Upper-half store and upper-byte store into 0xDEADBEEF
        op("sh12",  H, 1, 0, 32'h12, 32'h0000BEEF, 1, 0, 0);
        op("lw10b", W, 0, 1, 32'h10, 32'h0,        1, 0, 32'hBEEFBEEF);
        op("sb13",  B, 1, 0, 32'h13, 32'h12345677, 1, 0, 0);
        op("lw10c", W, 0, 1, 32'h10, 32'h0,        1, 0, 32'h77EFBEEF);
        op("lb11",  B, 0, 1, 32'h11, 32'h0,        1, 0, 32'hFFFFFFBE);
        op("lbu13", BU,0, 1, 32'h13, 32'h0,        1, 0, 32'h00000077);

        // Misaligned requests are dropped
        op("sw40",   W, 1, 0, 32'h40, 32'hCAFEF00D, 0, 0, 0);
        op("sw41",   W, 1, 0, 32'h41, 32'h00000000, 0, 1, 0);
        op("sh43",   H, 1, 0, 32'h43, 32'h00000000, 0, 1, 0);
        op("lw42",   W, 0, 1, 32'h42, 32'h0,        0, 1, 0);
        op("f3_011", 3'b011, 0, 1, 32'h40, 32'h0,   0, 1, 0);
        op("lw40",   W, 0, 1, 32'h40, 32'h0,        1, 0, 32'hCAFEF00D);

        // Address wrap-around
        op("sw400", W, 1, 0, 32'h400, 32'h5A5A5A5A, 0, 0, 0);
        op("lw000", W, 0, 1, 32'h000, 32'h0,        1, 0, 32'h5A5A5A5A);

        // Store and load requested together: store only
        op("swld60", W, 1, 1, 32'h60, 32'h0BADCAFE, 0, 0, 0);
        op("lw60",   W, 0, 1, 32'h60, 32'h0,        1, 0, 32'h0BADCAFE);

        // Reset in the MERGE cycle
        op("sw50", W, 1, 0, 32'h50, 32'h12345678, 0, 0, 0);
        iFunct3      = B;
        iData_WrEn   = 1'b1;
        iData_Addr   = 32'h50;
        iData_WrData = 32'h000000FF;
        @(negedge iClk);
        check("sb50_stall", {31'd0, oStall}, 32'd1);
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        #1;
        check("rstm_rddata",   oData_RdData, 32'd0);
        check("rstm_rdvalid",  {31'd0, oRdValid}, 32'd0);
        check("rstm_stall",    {31'd0, oStall}, 32'd0);
        check("rstm_misalign", {31'd0, oMisalign}, 32'd0);
        // Keep the request held across an edge while reset is low.
        @(posedge iClk);
        #1;
        check("rstm_stall_held", {31'd0, oStall}, 32'd0);
        iData_WrEn = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        op("lw50", W, 0, 1, 32'h50, 32'h0, 1, 0, 32'h12345678);

        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check("scoreboard_drain", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
